// File: rtl/jt51_ring_pkg.sv
// Shared definitions for the slot-domain ring blocks:
// slot index width and write-port FSM encoding.
package jt51_ring_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } wr_st_t;

    function automatic int slot_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jt51_slot_cnt.sv
// Wrapping slot counter, advances on cen, with a
// decoded marker for slot zero.
module jt51_slot_cnt
    import jt51_ring_pkg::*;
#(
    parameter int stages = 32,
    localparam int sw = slot_w(stages)
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    output logic [sw-1:0] cnt,
    output logic          zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cen) begin
            // power-of-two length: natural overflow wraps
            cnt <= cnt + sw'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/jt51_slot_ring.sv
// Circulating per-slot parameter ring with a single
// pending CPU write merged when its slot passes.
module jt51_slot_ring
    import jt51_ring_pkg::*;
#(
    parameter int width  = 5,
    parameter int stages = 32,
    localparam int sw = slot_w(stages)
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             cen,
    input  logic             wr_req,
    input  logic [sw-1:0]    wr_slot,
    input  logic [width-1:0] wr_data,
    output logic             wr_busy,
    output logic [sw-1:0]    cur_slot,
    output logic             zero,
    output logic [width-1:0] dout
);

    localparam int rw = stages * width;

    logic [rw-1:0]    ring;
    logic [width-1:0] head;
    logic [width-1:0] inject;
    logic [sw-1:0]    pend_slot;
    logic [width-1:0] pend_data;
    logic             commit;
    wr_st_t           st;

    jt51_slot_cnt #(
        .stages (stages)
    ) u_cnt (
        .rst  (rst),
        .clk  (clk),
        .cen  (cen),
        .cnt  (cur_slot),
        .zero (zero)
    );

    assign head    = ring[rw-1 -: width];
    assign dout    = head;
    assign wr_busy = (st == PEND);
    assign commit  = (st == PEND) && (cur_slot == pend_slot);
    assign inject  = commit ? pend_data : head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring <= '0;
        end else if (cen) begin
            ring <= {ring[rw-width-1:0], inject};
        end
    end

    // requests are taken on any edge; commits only on enabled ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            pend_slot <= '0;
            pend_data <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (wr_req) begin
                        pend_slot <= wr_slot;
                        pend_data <= wr_data;
                        st        <= PEND;
                    end
                end
                PEND: begin
                    if (cen && commit) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt51_slot_ring.sv
// Randomized and directed check of jt51_slot_ring
// against a slot-indexed memory model.
module tb_jt51_slot_ring;

    localparam int W  = 5;
    localparam int N  = 32;
    localparam int SW = 5;

    logic          rst;
    logic          clk;
    logic          cen;
    logic          wr_req;
    logic [SW-1:0] wr_slot;
    logic [W-1:0]  wr_data;
    logic          wr_busy;
    logic [SW-1:0] cur_slot;
    logic          zero;
    logic [W-1:0]  dout;

    int checks = 0;
    int errors = 0;

    int mem [N];
    int m_cur;
    bit m_pend;
    int m_ps;
    int m_pd;

    jt51_slot_ring #(
        .width  (W),
        .stages (N)
    ) dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .wr_req   (wr_req),
        .wr_slot  (wr_slot),
        .wr_data  (wr_data),
        .wr_busy  (wr_busy),
        .cur_slot (cur_slot),
        .zero     (zero),
        .dout     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: one stored value per slot; dout shows the current slot.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] = 0;
            m_cur  = 0;
            m_pend = 0;
            m_ps   = 0;
            m_pd   = 0;
        end else begin
            if (!m_pend) begin
                if (wr_req) begin
                    m_pend = 1;
                    m_ps   = int'(wr_slot);
                    m_pd   = int'(wr_data);
                end
            end else if (cen && m_cur == m_ps) begin
                mem[m_ps] = m_pd;
                m_pend    = 0;
            end
            if (cen) m_cur = (m_cur + 1) % N;
        end
    end

    always @(negedge clk) begin
        chk("cur_slot", int'(cur_slot), m_cur);
        chk("zero", int'(zero), int'(m_cur == 0));
        chk("dout", int'(dout), mem[m_cur]);
        chk("wr_busy", int'(wr_busy), int'(m_pend));
    end

    task automatic wait_slot(input int s);
        int n = 0;
        while (int'(cur_slot) != s && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_slot %0d: timeout, at %0d", s, cur_slot);
        end
    endtask

    task automatic request(input int s, input int d);
        wr_req  = 1'b1;
        wr_slot = SW'(s);
        wr_data = W'(d);
        @(negedge clk);
        wr_req  = 1'b0;
    endtask

    initial begin
        int n;
        int zc;
        rst     = 1'b1;
        cen     = 1'b0;
        wr_req  = 1'b0;
        wr_slot = '0;
        wr_data = '0;
        #12;
        rst = 1'b0;
        chk("rst_cur", int'(cur_slot), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_dout", int'(dout), 0);
        chk("rst_busy", int'(wr_busy), 0);

        // free-running, no writes
        @(negedge clk);
        cen = 1'b1;
        zc  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (zero) zc++;
        end
        chk("zero_count", zc, 2);

        // slot 10 written from slot 3; dropped second request
        wait_slot(3);
        request(10, 'h15);
        n = 0;
        while (wr_busy && n < 100) begin
            n++;
            wr_req  = (n == 1);
            wr_slot = 2;
            wr_data = 'h1F;
            @(negedge clk);
        end
        wr_req = 1'b0;
        chk("busy_len_10", n, 7);
        wait_slot(10);
        chk("slot10_val", int'(dout), 'h15);
        wait_slot(2);
        chk("slot2_val", int'(dout), 0);

        // request on the target slot waits a full lap
        wait_slot(5);
        request(5, 'h0A);
        n = 0;
        while (wr_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len_5", n, 32);
        wait_slot(5);
        chk("slot5_val", int'(dout), 'h0A);

        // cen 1-of-3 with a pending write
        request(17, 'h09);
        for (int i = 0; i < 300; i++) begin
            cen = (i % 3 == 0);
            @(negedge clk);
        end
        cen = 1'b1;
        wait_slot(17);
        chk("slot17_val", int'(dout), 'h09);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cen     = ($urandom_range(3) != 0);
            wr_req  = ($urandom_range(4) == 0);
            wr_slot = SW'($urandom);
            wr_data = W'($urandom);
            @(negedge clk);
        end
        wr_req = 1'b0;
        cen    = 1'b1;

        // async reset while a write is pending
        n = 0;
        while (wr_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        request(20, 'h11);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(wr_busy), 0);
        chk("arst_dout", int'(dout), 0);
        chk("arst_cur", int'(cur_slot), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        wait_slot(20);
        chk("slot20_val", int'(dout), 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
